// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA pixel-source slice.
//   ACT_W / ACT_H : active-area size of the 800x600 timing driver
//   rgb24         : packed {r, g, b} pixel
//   pos_t         : 11-bit screen coordinate
//   dir_t/axis_t  : per-axis motion state used by the bounce controller
//   reflect()     : one STEP of motion on one axis, reflecting at the edges
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int ACT_W = 800;
  localparam int ACT_H = 600;

  typedef logic [23:0] rgb24;
  typedef logic [10:0] pos_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef struct packed {
    pos_t pos;
    dir_t dir;
  } axis_t;

  // Advances one axis by one frame. The far edge is summed in 12 bits so
  // that pos+size+step cannot wrap before it is compared with the limit.
  // Hitting an edge clamps to it and flips direction for the next frame.
  function automatic axis_t reflect(axis_t cur, int lim, int size, int step);
    axis_t       nxt;
    logic [11:0] farEdge;
    nxt     = cur;
    farEdge = {1'b0, cur.pos} + 12'(size) + 12'(step);
    if (cur.dir == DIR_POS && farEdge > 12'(lim)) begin
      nxt.pos = pos_t'(lim - size);
      nxt.dir = DIR_NEG;
    end else if (cur.dir == DIR_NEG && {1'b0, cur.pos} < 12'(1 + step)) begin
      nxt.pos = pos_t'(1);
      nxt.dir = DIR_POS;
    end else if (cur.dir == DIR_POS) begin
      nxt.pos = cur.pos + pos_t'(step);
    end else begin
      nxt.pos = cur.pos - pos_t'(step);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_pic_bounce_if.sv
// ---------------------------------------------------------------------------
// vga_pic_bounce_if
// Pixel bus between the VGA timing driver, the picture source and its ROM.
//   value_x/value_y : active coordinates from the driver (0 = blanking)
//   rgb             : pixel returned to the driver
//   rom_addr        : picture ROM address
//   rom_data        : ROM read data, valid one clock after rom_addr
// slave  : the picture source (vga_pic_bounce)
// master : driver + ROM side
// ---------------------------------------------------------------------------
interface vga_pic_bounce_if #(
  parameter int ADDR_W = 14
);
  import vga_pkg::*;

  pos_t              value_x;
  pos_t              value_y;
  rgb24              rgb;
  logic [ADDR_W-1:0] rom_addr;
  rgb24              rom_data;

  modport slave (
    input  value_x,
    input  value_y,
    input  rom_data,
    output rgb,
    output rom_addr
  );

  modport master (
    output value_x,
    output value_y,
    output rom_data,
    input  rgb,
    input  rom_addr
  );

endinterface

// File: rtl/vga_bounce_ctrl.sv
// ---------------------------------------------------------------------------
// vga_bounce_ctrl
// Holds the picture position and direction and moves it once per frame.
//   clk, rst_n   : pixel clock, async active-low reset
//   frame_tick_i : one-clock pulse at the start of each frame
//   mode_i       : 0 = parked at (INIT_X, INIT_Y), 1 = bounce
//   pos_x_o      : current left column of the picture
//   pos_y_o      : current top row of the picture
// ---------------------------------------------------------------------------
module vga_bounce_ctrl #(
  parameter int ACT_W  = vga_pkg::ACT_W,
  parameter int ACT_H  = vga_pkg::ACT_H,
  parameter int PIC_W  = 128,
  parameter int PIC_H  = 128,
  parameter int STEP   = 2,
  parameter int INIT_X = 100,
  parameter int INIT_Y = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick_i,
  input  logic          mode_i,
  output vga_pkg::pos_t pos_x_o,
  output vga_pkg::pos_t pos_y_o
);
  import vga_pkg::*;

  localparam axis_t HOME_X = '{pos: pos_t'(INIT_X), dir: DIR_POS};
  localparam axis_t HOME_Y = '{pos: pos_t'(INIT_Y), dir: DIR_POS};

  axis_t axisX_q, axisX_d;
  axis_t axisY_q, axisY_d;

  // Position only changes on a frame tick. Leaving bounce mode is handled by
  // parking the picture back home on every tick while mode is 0, which also
  // restores both directions to positive.
  always_comb begin
    axisX_d = axisX_q;
    axisY_d = axisY_q;
    if (frame_tick_i) begin
      if (mode_i) begin
        axisX_d = reflect(axisX_q, ACT_W, PIC_W, STEP);
        axisY_d = reflect(axisY_q, ACT_H, PIC_H, STEP);
      end else begin
        axisX_d = HOME_X;
        axisY_d = HOME_Y;
      end
    end
  end

  // Motion state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axisX_q <= HOME_X;
      axisY_q <= HOME_Y;
    end else begin
      axisX_q <= axisX_d;
      axisY_q <= axisY_d;
    end
  end

  assign pos_x_o = axisX_q.pos;
  assign pos_y_o = axisY_q.pos;

endmodule

// File: rtl/vga_pic_bounce.sv
// ---------------------------------------------------------------------------
// vga_pic_bounce
// Pixel source placed in front of the VGA timing driver. Draws a PIC_W x PIC_H
// picture from an external synchronous ROM over a flat background, optionally
// bouncing it around the active area. Fixed 3-clock latency from coordinates
// to rgb, so the picture shows up 3 pixels right of pos_x on screen.
//   clk, rst_n   : pixel clock, async active-low reset
//   bus          : pixel bus (coordinates in, rgb out, ROM address/data)
//   mode_i       : 0 = static at (INIT_X, INIT_Y), 1 = bounce
//   pos_x_o      : current picture left column
//   pos_y_o      : current picture top row
//   frame_tick_o : one-clock pulse after the first active pixel of a frame
// ---------------------------------------------------------------------------
module vga_pic_bounce #(
  parameter int            ACT_W    = vga_pkg::ACT_W,
  parameter int            ACT_H    = vga_pkg::ACT_H,
  parameter int            PIC_W    = 128,
  parameter int            PIC_H    = 128,
  parameter int            ADDR_W   = 14,
  parameter int            STEP     = 2,
  parameter int            INIT_X   = 100,
  parameter int            INIT_Y   = 100,
  parameter vga_pkg::rgb24 BG_COLOR = 24'h000000
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_pic_bounce_if.slave  bus,
  input  logic             mode_i,
  output vga_pkg::pos_t    pos_x_o,
  output vga_pkg::pos_t    pos_y_o,
  output logic             frame_tick_o
);
  import vga_pkg::*;

  localparam int XW = $clog2(PIC_W);
  localparam int YW = $clog2(PIC_H);

  pos_t              posX, posY;
  logic              active, inBox, tick_d;
  logic [11:0]       xEnd, yEnd;
  logic [XW-1:0]     xOff;
  logic [YW-1:0]     yOff;
  logic [ADDR_W-1:0] romAddr_q, romAddr_d;
  pos_t              lastY_q, lastY_d;
  logic              tick_q;
  logic              v1_q, act1_q, v2_q, act2_q;
  rgb24              rgb_q, rgb_d;

  vga_bounce_ctrl #(
    .ACT_W  (ACT_W),
    .ACT_H  (ACT_H),
    .PIC_W  (PIC_W),
    .PIC_H  (PIC_H),
    .STEP   (STEP),
    .INIT_X (INIT_X),
    .INIT_Y (INIT_Y)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (tick_q),
    .mode_i       (mode_i),
    .pos_x_o      (posX),
    .pos_y_o      (posY)
  );

  // Stage 1 and frame detect. The box end is summed in 12 bits so a picture
  // near the right/bottom edge cannot wrap. The ROM address is the offset
  // inside the picture and simply holds while outside it. A new frame is a
  // drop in value_y between active pixels; blanking (0) never updates
  // last_y, so it cannot fake a frame start.
  always_comb begin
    active    = (bus.value_x != '0) && (bus.value_y != '0);
    xEnd      = {1'b0, posX} + 12'(PIC_W);
    yEnd      = {1'b0, posY} + 12'(PIC_H);
    inBox     = active
                && (bus.value_x >= posX) && ({1'b0, bus.value_x} < xEnd)
                && (bus.value_y >= posY) && ({1'b0, bus.value_y} < yEnd);
    xOff      = XW'(bus.value_x - posX);
    yOff      = YW'(bus.value_y - posY);
    romAddr_d = romAddr_q;
    if (inBox) begin
      romAddr_d = ADDR_W'({yOff, xOff});
    end
    lastY_d = active ? bus.value_y : lastY_q;
    tick_d  = active && (bus.value_y < lastY_q);
  end

  // Stage 3 output mux: picture pixel, background inside the active area,
  // black during blanking.
  always_comb begin
    rgb_d = '0;
    if (v2_q) begin
      rgb_d = bus.rom_data;
    end else if (act2_q) begin
      rgb_d = BG_COLOR;
    end
  end

  // Pipeline and frame-detect registers. Reset flushes every in-flight pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      romAddr_q <= '0;
      v1_q      <= 1'b0;
      act1_q    <= 1'b0;
      v2_q      <= 1'b0;
      act2_q    <= 1'b0;
      rgb_q     <= '0;
      lastY_q   <= '0;
      tick_q    <= 1'b0;
    end else begin
      romAddr_q <= romAddr_d;
      v1_q      <= inBox;
      act1_q    <= active;
      v2_q      <= v1_q;
      act2_q    <= act1_q;
      rgb_q     <= rgb_d;
      lastY_q   <= lastY_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.rom_addr = romAddr_q;
  assign bus.rgb      = rgb_q;
  assign pos_x_o      = posX;
  assign pos_y_o      = posY;
  assign frame_tick_o = tick_q;

endmodule
